// File: rtl/cplx_dot_engine.sv
// Streaming complex dot-product engine: sum of a[k]*b[k] (or a[k]*conj(b[k])) over VEC_LEN pairs.
// Latency: result valid 3 edges after the last accepted pair. Backpressure: in_ready drops from the last pair until the result is taken.
// Define CPLX_DOT_SAT_EN to saturate out-of-range results; otherwise the low OUT_W bits are output.
module cplx_dot_engine #(
   parameter int DATA_W    = 8,
   parameter int VEC_LEN   = 4,
   parameter int ACC_W     = 2*DATA_W + 1 + $clog2(VEC_LEN),
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic                     conj_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_re,
   output logic signed [OUT_W-1:0]  out_im,
   output logic                     out_sat,
   output logic                     busy
);

   localparam int CNT_W  = $clog2(VEC_LEN + 1);
   localparam int PROD_W = 2 * DATA_W;
   localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [1:0]                flush_q;
   logic                      conj_q;
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic                      out_sat_q;
   logic signed [OUT_W-1:0]   out_re_q, out_im_q;
   logic                      in_xfer;

   logic signed [PROD_W-1:0]  p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic                      s1_vld_q, s1_first_q, s2_vld_q;

   logic signed [ACC_W-1:0]   x_rr, x_ii, x_ri, x_ir;
   logic signed [ACC_W-1:0]   term_re, term_im;
   logic signed [ACC_W-1:0]   acc_re_d, acc_im_d, acc_re_q, acc_im_q;

   logic signed [OUT_W-1:0]   sc_re, sc_im;
   logic                      sc_re_sat, sc_im_sat;

   assign in_xfer = in_valid && in_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_rr_q     <= '0;
         p_ii_q     <= '0;
         p_ri_q     <= '0;
         p_ir_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
      end else begin
         s1_vld_q <= in_xfer;
         if (in_xfer) begin
            p_rr_q     <= a_re * b_re;
            p_ii_q     <= a_im * b_im;
            p_ri_q     <= a_re * b_im;
            p_ir_q     <= a_im * b_re;
            s1_first_q <= (state_q == IDLE);
         end
      end
   end

   assign x_rr = ACC_W'(p_rr_q);
   assign x_ii = ACC_W'(p_ii_q);
   assign x_ri = ACC_W'(p_ri_q);
   assign x_ir = ACC_W'(p_ir_q);

   // conj_q is already latched by the time the first element reaches this stage.
   always_comb begin
      term_re  = conj_q ? (x_rr + x_ii) : (x_rr - x_ii);
      term_im  = conj_q ? (x_ir - x_ri) : (x_ri + x_ir);
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      if (s1_vld_q) begin
         acc_re_d = s1_first_q ? term_re : (acc_re_q + term_re);
         acc_im_d = s1_first_q ? term_im : (acc_im_q + term_im);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_re_q <= '0;
         acc_im_q <= '0;
         s2_vld_q <= 1'b0;
      end else begin
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         s2_vld_q <= s1_vld_q;
      end
   end

   // Returns {clipped, value}; the value is either saturated or the wrapped low bits.
   function automatic logic [OUT_W:0] scale(input logic signed [ACC_W-1:0] acc);
`ifdef CPLX_DOT_SAT_EN
      logic signed [EXT_W-1:0]   shx;
      logic [EXT_W-OUT_W:0]      top;
      shx = EXT_W'(acc) >>> OUT_SHIFT;
      top = shx[EXT_W-1:OUT_W-1];
      if ((&top) || !(|top))
         scale = {1'b0, shx[OUT_W-1:0]};
      else
         scale = {1'b1, shx[EXT_W-1], {(OUT_W-1){~shx[EXT_W-1]}}};
`else
      scale = {1'b0, OUT_W'(EXT_W'(acc) >>> OUT_SHIFT)};
`endif
   endfunction

   assign {sc_re_sat, sc_re} = scale(acc_re_q);
   assign {sc_im_sat, sc_im} = scale(acc_im_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         flush_q     <= '0;
         conj_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_xfer) begin
                  conj_q  <= conj_b;
                  cnt_q   <= CNT_W'(1);
                  flush_q <= '0;
                  if (VEC_LEN == 1) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (in_xfer) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                     flush_q    <= '0;
                  end
               end
            end
            FLUSH: begin
               // Two drain edges let the last product pass through both stages.
               if (flush_q == 2'd2) begin
                  out_re_q    <= sc_re;
                  out_im_q    <= sc_im;
                  out_sat_q   <= sc_re_sat | sc_im_sat;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else begin
                  flush_q <= flush_q + 2'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q != IDLE) || s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_cplx_dot_engine.sv
// Scoreboard bench for cplx_dot_engine at default parameters; expectations follow CPLX_DOT_SAT_EN.
module tb_cplx_dot_engine;

   localparam int DATA_W  = 8;
   localparam int VEC_LEN = 4;
   localparam int OUT_W   = 16;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [DATA_W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic                     conj_b = 1'b0;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [OUT_W-1:0]         out_re, out_im;
   logic                     out_sat;
   logic                     busy;

   always #5 clk = ~clk;

   cplx_dot_engine dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .conj_b(conj_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_sat(out_sat),
      .busy(busy)
   );

   typedef struct {
      logic [OUT_W-1:0] re;
      logic [OUT_W-1:0] im;
      logic             sat;
   } exp_t;

   exp_t    sb_q[$];
   exp_t    mon_e;
   int      total = 0;
   int      bad = 0;
   int      xfer_cnt = 0;
   longint  model_re, model_im;
   bit      mconj;
   int      elem_idx = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void clip(input longint v, output logic [OUT_W-1:0] o, output logic s);
`ifdef CPLX_DOT_SAT_EN
      if (v > 32767) begin
         o = 16'h7fff; s = 1'b1;
      end else if (v < -32768) begin
         o = 16'h8000; s = 1'b1;
      end else begin
         o = v[15:0]; s = 1'b0;
      end
`else
      o = v[15:0];
      s = 1'b0;
`endif
   endfunction

   task automatic send_elem(input int ar, input int ai, input int br, input int bi, input bit cj);
      longint pr, pi;
      int n;
      logic [OUT_W-1:0] er, ei;
      logic sr, si;
      if (elem_idx == 0) mconj = cj;
      pr = mconj ? longint'(ar*br + ai*bi) : longint'(ar*br - ai*bi);
      pi = mconj ? longint'(ai*br - ar*bi) : longint'(ar*bi + ai*br);
      model_re = (elem_idx == 0) ? pr : model_re + pr;
      model_im = (elem_idx == 0) ? pi : model_im + pi;
      a_re = DATA_W'(ar); a_im = DATA_W'(ai);
      b_re = DATA_W'(br); b_im = DATA_W'(bi);
      conj_b = cj;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      elem_idx++;
      if (elem_idx == VEC_LEN) begin
         clip(model_re, er, sr);
         clip(model_im, ei, si);
         sb_q.push_back('{re: er, im: ei, sat: sr | si});
         elem_idx = 0;
      end
   endtask

   task automatic send_same(input int ar, input int ai, input int br, input int bi, input bit cj);
      for (int k = 0; k < VEC_LEN; k++) send_elem(ar, ai, br, bi, cj);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 64'(n < 200), 64'd1);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         xfer_cnt++;
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_re", 64'(out_re), 64'(mon_e.re));
            chk("out_im", 64'(out_im), 64'(mon_e.im));
            chk("out_sat", 64'(out_sat), 64'(mon_e.sat));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, xc;
      logic [OUT_W-1:0] hr, hi;
      logic hs;

      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_re", 64'(out_re), 64'd0);
      chk("rst_out_im", 64'(out_im), 64'd0);
      chk("rst_out_sat", 64'(out_sat), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // (1+2i)*(3+4i) x4 = -20+40i, with latency check
      send_same(1, 2, 3, 4, 1'b0);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'd3);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      drain();

      // conj on first element only; later toggles ignored -> 44+8i
      send_elem(1, 2, 3, 4, 1'b1);
      send_elem(1, 2, 3, 4, 1'b0);
      send_elem(1, 2, 3, 4, 1'b1);
      send_elem(1, 2, 3, 4, 1'b0);
      drain();

      // positive overflow: |(-128-128i)|^2 x4 = 131072
      send_same(-128, -128, -128, -128, 1'b1);
      drain();
      // negative overflow: -128*127 x4 = -65024
      send_same(-128, 0, 127, 0, 1'b0);
      drain();

      // backpressure: result held for 10 cycles
      out_ready = 1'b0;
      send_same(3, -2, -1, 5, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_seen", 64'(out_valid), 64'd1);
      hr = out_re; hi = out_im; hs = out_sat;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("hold_stable", 64'({out_valid, in_ready, out_re, out_im, out_sat}),
             64'({1'b1, 1'b0, hr, hi, hs}));
      end
      xc = xfer_cnt;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_ready", 64'(in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("single_xfer", 64'(xfer_cnt - xc), 64'd1);

      // gapped input: two idle cycles between elements -> 40+0i
      for (int k = 0; k < VEC_LEN; k++) begin
         send_elem(2, 0, 5, 0, 1'b0);
         if (k < VEC_LEN - 1) begin
            repeat (2) @(posedge clk);
            #1;
            chk("gap_ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
         end
      end
      drain();

      // asynchronous reset after 2 of 4 elements
      send_elem(7, 7, 7, 7, 1'b0);
      send_elem(7, 7, 7, 7, 1'b0);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_outs", 64'({out_valid, out_sat, out_re, out_im}), 64'd0);
      elem_idx = 0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send_elem(1, -1, 2, 3, 1'b0);
      send_elem(-4, 6, 0, -2, 1'b0);
      send_elem(5, 5, -5, 5, 1'b0);
      send_elem(-9, 1, 3, 8, 1'b0);
      drain();

      // random vectors with random conj and gaps
      for (int v = 0; v < 6; v++) begin
         bit cj;
         cj = 1'($urandom_range(0, 1));
         for (int k = 0; k < VEC_LEN; k++) begin
            send_elem(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, cj);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         drain();
      end

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
